// File: rtl/alu_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | alu_seq: handshaked EX-stage ALU, NZCV flags, multi-cycle MUL / UDIV.  |
// | Optional macro ALU_SEQ_SDIV_EN enables SDIV on opcode 1011.            |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module alu_seq #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctl,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_LSL  = 4'b0011;
  localparam logic [3:0] OP_LSR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_UDIV = 4'b1001;
  localparam logic [3:0] OP_EOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
`ifdef ALU_SEQ_SDIV_EN
  localparam logic [3:0] OP_SDIV = 4'b1011;
`endif

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t state, state_nx;

  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;
  logic             sf_q;
  // Shared iteration registers: MUL uses acc/multiplicand/multiplier,
  // divide uses remainder/divisor/dividend-becoming-quotient.
  logic [WIDTH-1:0] x, y, z;
  logic [WIDTH-1:0] x_step, y_step, z_step;

  logic             is_mul, is_div, sc_legal, one_shot, b_nz;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v;
  logic [WIDTH:0]   sum, diff;
  logic [CNT_W-2:0] shamt;
  logic             shamt_ovf;
  logic [WIDTH:0]   div_sh, div_trial;
  logic [WIDTH-1:0] div_a, div_b, quot, fin_res;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid & in_ready;
  assign last_iter = (cnt == CNT_ONE);
  assign b_nz      = (b != '0);

  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt     = b[CNT_W-2:0];
  assign shamt_ovf = ({1'b0, shamt} >= CNT_LOAD);

`ifdef ALU_SEQ_SDIV_EN
  logic div_signed, neg_q;
  // Divide on magnitudes; the sign is restored when the quotient completes.
  assign div_a = (div_signed && a[MSB]) ? -a : a;
  assign div_b = (div_signed && b[MSB]) ? -b : b;
  assign quot  = neg_q ? -z_step : z_step;
`else
  assign div_a = a;
  assign div_b = b;
  assign quot  = z_step;
`endif

  always_comb begin
    sc_res   = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_legal = 1'b1;
    is_mul   = 1'b0;
    is_div   = 1'b0;
`ifdef ALU_SEQ_SDIV_EN
    div_signed = 1'b0;
`endif
    case (alu_ctl)
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_ADD: begin
        sc_res = sum[MSB:0];
        sc_c   = sum[WIDTH];
        sc_v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_LSL:  sc_res = shamt_ovf ? '0 : (a << shamt);
      OP_LSR:  sc_res = shamt_ovf ? '0 : (a >> shamt);
      OP_SUB: begin
        sc_res = diff[MSB:0];
        sc_c   = diff[WIDTH];
        sc_v   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_PASS: sc_res = b;
      OP_EOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_MUL:  is_mul = 1'b1;
      OP_UDIV: is_div = 1'b1;
`ifdef ALU_SEQ_SDIV_EN
      OP_SDIV: begin
        is_div     = 1'b1;
        div_signed = 1'b1;
      end
`endif
      default: sc_legal = 1'b0;
    endcase
  end

  // Divide by zero finishes immediately with result 0 like any one-cycle op.
  assign one_shot = sc_legal & ~is_mul & ~(is_div & b_nz);

  assign div_sh    = {x, z[MSB]};
  assign div_trial = div_sh - {1'b0, y};

  always_comb begin
    if (state == S_MUL) begin
      x_step = z[0] ? (x + y) : x;
      y_step = y << 1;
      z_step = z >> 1;
    end else begin
      x_step = div_trial[WIDTH] ? div_sh[MSB:0] : div_trial[MSB:0];
      y_step = y;
      z_step = {z[MSB-1:0], ~div_trial[WIDTH]};
    end
  end

  assign fin_res = (state == S_MUL) ? x_step : quot;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_mul)              state_nx = S_MUL;
          else if (is_div && b_nz) state_nx = S_DIV;
          else                     state_nx = S_DONE;
        end
      end
      S_MUL, S_DIV: if (last_iter) state_nx = S_DONE;
      S_DONE:       if (out_ready) state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result  <= '0;
      flags   <= 4'b0000;
      illegal <= 1'b0;
      cnt     <= '0;
      sf_q    <= 1'b0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
`ifdef ALU_SEQ_SDIV_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            result  <= sc_res;
            illegal <= ~sc_legal;
            sf_q    <= set_flags;
            x       <= '0;
            if (is_mul) begin
              y   <= a;
              z   <= b;
              cnt <= CNT_LOAD;
            end else if (is_div) begin
              y   <= div_b;
              z   <= div_a;
              cnt <= CNT_LOAD;
`ifdef ALU_SEQ_SDIV_EN
              neg_q <= div_signed & (a[MSB] ^ b[MSB]);
`endif
            end
            if (one_shot && set_flags)
              flags <= {sc_res[MSB], (sc_res == '0), sc_c, sc_v};
          end
        end
        S_MUL, S_DIV: begin
          x   <= x_step;
          y   <= y_step;
          z   <= z_step;
          cnt <= cnt - CNT_ONE;
          if (last_iter) begin
            result <= fin_res;
            if (sf_q)
              flags <= {fin_res[MSB], (fin_res == '0), 2'b00};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_alu_seq: directed scoreboard bench for alu_seq at WIDTH=8.          |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_alu_seq;
  localparam int W  = 8;
  localparam int CW = $clog2(W) + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_ctl;
  logic         set_flags;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         illegal;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_ctl   (alu_ctl),
    .set_flags (set_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .illegal   (illegal)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
    logic         ill;
    int           lat;
    int           hold;
    int           acc;
    string        name;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input string nm, input logic [3:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic sf, input logic [W-1:0] er,
                       input logic [3:0] ef, input logic ei, input int lat, input int hold);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_accept_timeout: got in_ready=0, expected 1", nm);
      return;
    end
    e.res  = er;
    e.flg  = ef;
    e.ill  = ei;
    e.lat  = lat;
    e.hold = hold;
    e.acc  = cyc + 1;
    e.name = nm;
    sbq.push_back(e);
    in_valid  = 1'b1;
    alu_ctl   = op;
    a         = av;
    b         = bv;
    set_flags = sf;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((sbq.size() != 0 || out_valid) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", sbq.size(), 0);
  endtask

  // Monitor: compares every cycle the DUT presents a result, pops on handshake.
  initial begin : monitor
    exp_t e;
    int   hold;
    bit   first;
    bit   busy_ready;
    hold       = 0;
    first      = 1'b1;
    busy_ready = 1'b0;
    out_ready  = 1'b1;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got out_valid=1 result=0x%0h, expected no pending op", result);
          out_ready = 1'b1;
        end else begin
          e = sbq[0];
          if (first) begin
            check({e.name, "_latency"}, cyc - e.acc + 1, e.lat);
            check({e.name, "_in_ready_busy"}, busy_ready, 0);
            hold  = e.hold;
            first = 1'b0;
          end
          check({e.name, "_result"}, result, e.res);
          check({e.name, "_flags"}, flags, e.flg);
          check({e.name, "_illegal"}, illegal, e.ill);
          if (hold > 0) begin
            out_ready = 1'b0;
            hold--;
          end else begin
            out_ready = 1'b1;
            void'(sbq.pop_front());
            first      = 1'b1;
            busy_ready = 1'b0;
          end
        end
      end else if (sbq.size() != 0 && cyc >= sbq[0].acc && in_ready === 1'b1) begin
        busy_ready = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    alu_ctl   = 4'b0000;
    set_flags = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_flags", flags, 4'b0000);
    check("reset_illegal", illegal, 0);
    rst = 1'b0;

    //    name         op       a      b      sf    result flags    ill lat hold
    issue("add_ovf",   4'b0010, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b1001, 0, 1, 0);
    issue("sub_eq",    4'b0110, 8'h05, 8'h05, 1'b1, 8'h00, 4'b0110, 0, 1, 0);
    issue("and_nf",    4'b0000, 8'h03, 8'h04, 1'b0, 8'h00, 4'b0110, 0, 1, 0);
    issue("add_cv",    4'b0010, 8'h80, 8'h80, 1'b1, 8'h00, 4'b0111, 0, 1, 0);
    issue("sub_brw",   4'b0110, 8'h03, 8'h05, 1'b1, 8'hFE, 4'b1000, 0, 1, 0);
    issue("eor",       4'b1010, 8'hAA, 8'h0F, 1'b0, 8'hA5, 4'b1000, 0, 1, 0);
    issue("lsl",       4'b0011, 8'h03, 8'h03, 1'b0, 8'h18, 4'b1000, 0, 1, 0);
    issue("lsr7",      4'b0100, 8'h80, 8'h07, 1'b0, 8'h01, 4'b1000, 0, 1, 0);
    issue("lsr_trunc", 4'b0100, 8'h80, 8'h09, 1'b0, 8'h40, 4'b1000, 0, 1, 0);
    issue("or",        4'b0001, 8'h0F, 8'hF0, 1'b0, 8'hFF, 4'b1000, 0, 1, 0);
    issue("nor",       4'b1100, 8'h0F, 8'h30, 1'b1, 8'hC0, 4'b1000, 0, 1, 0);
    issue("pass_z",    4'b0111, 8'h12, 8'h00, 1'b1, 8'h00, 4'b0100, 0, 1, 0);
    issue("mul",       4'b1000, 8'd13, 8'd11, 1'b1, 8'h8F, 4'b1000, 0, 9, 3);
    issue("mul_wrap",  4'b1000, 8'hFF, 8'hFF, 1'b0, 8'h01, 4'b1000, 0, 9, 0);
    issue("udiv",      4'b1001, 8'd200, 8'd7, 1'b1, 8'h1C, 4'b0000, 0, 9, 0);
    issue("udiv_z",    4'b1001, 8'd5, 8'd0,   1'b1, 8'h00, 4'b0100, 0, 1, 0);
    issue("udiv_ff",   4'b1001, 8'hFF, 8'h01, 1'b0, 8'hFF, 4'b0100, 0, 9, 0);
    issue("ill_1110",  4'b1110, 8'h12, 8'h34, 1'b1, 8'h00, 4'b0100, 1, 1, 0);
    issue("ill_0101",  4'b0101, 8'h56, 8'h78, 1'b1, 8'h00, 4'b0100, 1, 1, 0);
`ifdef ALU_SEQ_SDIV_EN
    issue("sdiv",      4'b1011, 8'hF9, 8'h02, 1'b1, 8'hFD, 4'b1000, 0, 9, 0);
    issue("sdiv_min",  4'b1011, 8'h80, 8'hFF, 1'b1, 8'h80, 4'b1000, 0, 9, 0);
    issue("sdiv_z",    4'b1011, 8'h07, 8'h00, 1'b1, 8'h00, 4'b0100, 0, 1, 0);
`else
    issue("ill_1011",  4'b1011, 8'hF9, 8'h02, 1'b1, 8'h00, 4'b0100, 1, 1, 0);
`endif
    issue("add_clr",   4'b0010, 8'h01, 8'h01, 1'b0, 8'h02, 4'b0100, 0, 1, 0);
    wait_drain();

    // Reset in the fourth cycle of a MUL aborts it; nothing is scoreboarded.
    @(negedge clk);
    a         = 8'd13;
    b         = 8'd11;
    alu_ctl   = 4'b1000;
    set_flags = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_mid_busy", in_ready, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_flags", flags, 4'b0000);
    check("rst_mid_result", result, 0);
    issue("add_after_rst", 4'b0010, 8'd2, 8'd3, 1'b1, 8'd5, 4'b0000, 0, 1, 0);
    wait_drain();
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle LEGv8 execute ALU.
- Adds a latched NZCV flag register (for ADDS/SUBS/ANDS and the B.cond path), a correct carry flag, and multi-cycle MUL and UDIV.
- Sits in the EX stage; the pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 64, operand/result width in bits (must be >= 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- a  in  WIDTH  operand a, two's complement.
- b  in  WIDTH  operand b, two's complement.
- alu_ctl  in  4  opcode: AND=0000, OR=0001, ADD=0010, LSL=0011, LSR=0100, SUB=0110, PASS=0111, MUL=1000, UDIV=1001, EOR=1010, NOR=1100.
- set_flags  in  1  update NZCV when this operation completes.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  result.
- flags  out  4  registered {N,Z,C,V}.
- illegal  out  1  qualifies result: the opcode was unsupported.

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst).
- Reset:
  - state=IDLE; result=0; flags=4'b0000; out_valid=0; illegal=0; counter=0.
  - Reset mid-operation aborts the operation; flags are not updated.
- States IDLE, MUL, DIV, DONE.
- in_ready = (state==IDLE).
- Accept = in_valid & in_ready. Operands, opcode and set_flags are latched on accept.
- Single-cycle ops (all except MUL/UDIV):
  - IDLE -> DONE; out_valid=1 the cycle after accept (latency 1).
- Arithmetic:
  - ADD: WIDTH+1-bit sum; C=carry out; V=(a[msb]==b[msb]) & (sum[msb]!=a[msb]).
  - SUB: a + ~b + 1; C=1 when no borrow (a>=b unsigned); V=(a[msb]!=b[msb]) & (diff[msb]!=a[msb]).
  - LSL/LSR: shift amount b[CNT_W-2:0]; amount >= WIDTH gives 0. LSR is logical.
  - PASS: result=b. NOR: ~(a|b). EOR: a^b.
- MUL (low WIDTH bits, radix-2 shift-add):
  - IDLE -> MUL, counter=WIDTH; one bit per cycle.
  - MUL -> DONE when counter reaches 0; out_valid WIDTH+1 cycles after accept.
- UDIV (restoring, unsigned quotient):
  - IDLE -> DIV; WIDTH iterations; out_valid WIDTH+1 cycles after accept.
  - b==0: skip iterations; IDLE -> DONE in 1 cycle; result=0 (ARM semantics); not illegal.
- DONE:
  - Result is held stable while out_valid & ~out_ready.
  - out_valid & out_ready -> IDLE. A new op is accepted the following cycle, never in the same cycle.
- Flags: when set_flags is latched, flags update in the same edge that asserts out_valid.
  - N=result[msb], Z=(result==0).
  - ADD/SUB: C and V as above.
  - All other ops: C=0, V=0.
  - set_flags=0 leaves flags unchanged.
- Unused opcodes (0101, 1011, 1101–1111): 1-cycle; result=0; illegal=1; flags unchanged even if set_flags=1.
- illegal is valid only with out_valid and is cleared on the next accept.
- in_valid while busy is ignored; the producer must hold it.

Optional Feature:
- Macro ALU_SEQ_SDIV_EN.
- Defined: opcode 1011 = SDIV, a signed quotient truncated toward zero.
  - Implementation: magnitude restoring divide with sign fixup; WIDTH+1-cycle latency.
  - b==0 gives 0.
  - MIN/-1 gives MIN, with V=0 when flags are set.
- Not defined: 1011 is illegal as above; no sign-fixup logic is synthesised.

Test Plan:
- WIDTH=64: ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1, set_flags=1 -> result=0x8000_0000_0000_0000, flags N=1 Z=0 C=0 V=1, out_valid 1 cycle after accept.
- SUB a=5, b=5, set_flags=1 -> result=0, flags {0,1,1,0}. Then AND a=3, b=4, set_flags=0 -> result=0, flags unchanged {0,1,1,0}.
- WIDTH=8: MUL a=13, b=11 -> result=0x8F (143), out_valid exactly 9 cycles after accept, in_ready=0 throughout. Hold out_ready=0 for 3 cycles -> result stable.
- WIDTH=8: UDIV a=200, b=7 -> 28 after 9 cycles. UDIV a=5, b=0 -> 0 after 1 cycle, illegal=0.
- Assert rst for one cycle mid-MUL (cycle 4) -> next cycle: in_ready=1, out_valid=0, flags=0000. A following ADD 2+3 -> 5.
- alu_ctl=1110, set_flags=1 -> illegal=1, result=0, flags unchanged. With ALU_SEQ_SDIV_EN at WIDTH=8: SDIV a=-7 (0xF9), b=2 -> 0xFD (-3).
